// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing generator run enable and raster timing outputs
interface vga_timing_gen_if;
    logic       en;
    logic       pix_tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic       frame_start;

    modport master (
        input  en,
        output pix_tick, h_cnt, v_cnt, hsync, vsync, valid, frame_start
    );

    modport slave (
        output en,
        input  pix_tick, h_cnt, v_cnt, hsync, vsync, valid, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v counters, sync/visible decode
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_PIXELS = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_LINES  = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_PIXELS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_LINES + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic             r_frame_start;

    logic w_pix_tick;
    logic w_h_last;
    logic w_v_last;

    assign w_pix_tick = vif.en && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_h_last   = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_v_last   = (r_v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else if (vif.en) begin
            r_div         <= w_pix_tick ? '0 : r_div + DIV_W'(1);
            r_frame_start <= w_pix_tick && w_h_last && w_v_last;
            if (w_pix_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    // Decodes come straight off the counter registers so they never lag h_cnt/v_cnt.
    assign vif.pix_tick    = w_pix_tick;
    assign vif.h_cnt       = r_h_cnt;
    assign vif.v_cnt       = r_v_cnt;
    assign vif.hsync       = !((r_h_cnt >= 10'(H_PIXELS + H_FP)) &&
                               (r_h_cnt <  10'(H_PIXELS + H_FP + H_SYNC)));
    assign vif.vsync       = !((r_v_cnt >= 10'(V_LINES + V_FP)) &&
                               (r_v_cnt <  10'(V_LINES + V_FP + V_SYNC)));
    assign vif.valid       = (r_h_cnt < 10'(H_PIXELS)) && (r_v_cnt < 10'(V_LINES));
    assign vif.frame_start = r_frame_start && vif.en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (reduced raster plus default raster)
module tb_vga_timing_gen;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if s_if();
    vga_timing_gen_if d_if();

    // Reduced raster: 16 columns (8 visible, sync 10..12), 8 lines (4 visible, sync 5..6).
    vga_timing_gen #(
        .CLK_DIV(SD), .H_PIXELS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_LINES(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (.clk(clk), .rst(rst), .vif(s_if));

    vga_timing_gen u_dflt (.clk(clk), .rst(rst), .vif(d_if));

    typedef struct packed {
        logic       pt;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       va;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    int m_div = 0, m_h = 0, m_v = 0;
    bit m_fs = 0, m_known = 0;
    int cur_div, cur_h, cur_v;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle, push the expected outputs for it, then advance the model.
    task automatic step(input bit e, input bit r);
        exp_t x;
        bit   tick;
        @(posedge clk);
        #1;
        s_if.en = e;
        rst     = r;
        cur_div = m_div; cur_h = m_h; cur_v = m_v;
        if (m_known) begin
            x.pt = e && (m_div == SD - 1);
            x.h  = 10'(m_h);
            x.v  = 10'(m_v);
            x.hs = !(m_h >= 10 && m_h <= 12);
            x.vs = !(m_v >= 5 && m_v <= 6);
            x.va = (m_h < 8) && (m_v < 4);
            x.fs = m_fs && e;
            q.push_back(x);
        end
        if (!r) begin
            m_div = 0; m_h = 0; m_v = 0; m_fs = 0; m_known = 1;
        end else if (e) begin
            tick  = (m_div == SD - 1);
            m_fs  = tick && (m_h == 15) && (m_v == 7);
            m_div = (m_div + 1) % SD;
            if (tick) begin
                m_h = m_h + 1;
                if (m_h == 16) begin
                    m_h = 0;
                    m_v = (m_v + 1) % 8;
                end
            end
        end else begin
            m_fs = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t x, g;
        if (q.size() > 0) begin
            x = q.pop_front();
            g = {s_if.pix_tick, s_if.h_cnt, s_if.v_cnt, s_if.hsync, s_if.vsync,
                 s_if.valid, s_if.frame_start};
            checks++;
            if (g !== x) begin
                failures++;
                $display("FAIL scoreboard: got pt=%b h=%0d v=%0d hs=%b vs=%b va=%b fs=%b expected pt=%b h=%0d v=%0d hs=%b vs=%b va=%b fs=%b",
                         g.pt, g.h, g.v, g.hs, g.vs, g.va, g.fs,
                         x.pt, x.h, x.v, x.hs, x.vs, x.va, x.fs);
            end
        end
    end

    initial begin
        int first, last, npulse, bad, found, held, ticks, hs_low, hs_first, va_low;
        bit [15:0] en_pat;
        s_if.en = 1'b1;
        d_if.en = 1'b1;

        repeat (3) step(1, 0);
        #1;
        chk("rst_h_cnt", s_if.h_cnt, 0);
        chk("rst_v_cnt", s_if.v_cnt, 0);
        chk("rst_hsync", s_if.hsync, 1);
        chk("rst_vsync", s_if.vsync, 1);
        chk("rst_valid", s_if.valid, 1);
        chk("rst_pix_tick", s_if.pix_tick, 0);
        chk("rst_frame_start", s_if.frame_start, 0);
        chk("rst_dflt_h_cnt", d_if.h_cnt, 0);

        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 1);
            #1;
            if (s_if.pix_tick && first == 0) first = i;
            if (i == 5) chk("h_after_first_tick", s_if.h_cnt, 1);
            if (i <= 3) chk("no_frame_start_on_release", s_if.frame_start, 0);
        end
        chk("first_tick_cycle", first, 4);

        last = -1; npulse = 0; bad = 0;
        for (int i = 0; i < 1200; i++) begin
            step(1, 1);
            #1;
            if (s_if.frame_start) begin
                if (last >= 0 && (i - last) != 512) bad++;
                if (s_if.h_cnt != 0 || s_if.v_cnt != 0) bad++;
                last = i;
                npulse++;
            end
        end
        chk("frame_start_pulses", npulse, 2);
        chk("frame_start_period_err", bad, 0);

        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step(1, 1);
            #1;
            if (s_if.pix_tick && s_if.h_cnt == 15 && s_if.v_cnt == 1) found = 1;
        end
        chk("line_wrap_found", found, 1);
        step(1, 1);
        #1;
        chk("line_wrap_h", s_if.h_cnt, 0);
        chk("line_wrap_v", s_if.v_cnt, 2);

        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step(1, 1);
            if (cur_h == 5 && cur_div == 1) found = 1;
        end
        chk("pause_point_found", found, 1);
        ticks = 0; held = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            #1;
            if (s_if.pix_tick) ticks++;
            if (s_if.h_cnt != 5) held++;
        end
        chk("pause_ticks", ticks, 0);
        chk("pause_h_moved", held, 0);
        first = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1, 1);
            #1;
            if (s_if.pix_tick && first == 0) first = i;
        end
        chk("resume_tick_delay", first, 2);

        en_pat = 16'b1011_0011_1000_1101;
        for (int k = 0; k < 40; k++)
            for (int b = 0; b < 16; b++) step(en_pat[b], 1);

        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step(1, 1);
            if (cur_h == 5 && cur_v == 3) found = 1;
        end
        chk("midframe_point_found", found, 1);
        step(1, 0);
        step(1, 1);
        #1;
        chk("mid_rst_h_cnt", s_if.h_cnt, 0);
        chk("mid_rst_v_cnt", s_if.v_cnt, 0);
        chk("mid_rst_hsync", s_if.hsync, 1);
        chk("mid_rst_vsync", s_if.vsync, 1);
        chk("mid_rst_valid", s_if.valid, 1);
        chk("mid_rst_pix_tick", s_if.pix_tick, 0);
        chk("mid_rst_frame_start", s_if.frame_start, 0);

        found = 0;
        for (int i = 0; i < 3300 && found == 0; i++) begin
            @(posedge clk);
            #2;
            if (d_if.pix_tick && d_if.h_cnt == 799) found = 1;
        end
        chk("dflt_line_end_found", found, 1);
        hs_low = 0; hs_first = -1; va_low = 0;
        for (int i = 0; i < 3200; i++) begin
            @(posedge clk);
            #2;
            if (!d_if.hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = d_if.h_cnt;
            end
            if (!d_if.valid) va_low++;
        end
        chk("dflt_hsync_low_clks", hs_low, 384);
        chk("dflt_hsync_first_h", hs_first, 656);
        chk("dflt_valid_low_clks", va_low, 640);

        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
